// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: geometry, FSM
// state encodings and cache-op codes (ops used only with ICACHE_CACHEOP_EN).
package icache_pkg;
  localparam int LINES   = 512;
  localparam int WORDS   = 4096;
  localparam int INDEX_W = 9;
  localparam int TAG_W   = 20;
  localparam int WORD_W  = 3;
  localparam int DATA_AW = INDEX_W + WORD_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    OP_INDEX_INV = 3'd0,
    OP_HIT_INV   = 3'd4,
    OP_FILL      = 3'd5
  } cache_op_t;

  function automatic logic [INDEX_W-1:0] line_index(input logic [63:0] va);
    return va[13:5];
  endfunction
endpackage

// File: rtl/icache_ram.sv
// 4096x32 instruction data array: one write port, synchronous read port whose
// output register clears on reset.
module icache_ram
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DATA_AW-1:0] waddr,
  input  logic [31:0]        wdata,
  input  logic [DATA_AW-1:0] raddr,
  output logic [31:0]        rdata
);
  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/icache.sv
// Direct-mapped 16 KiB instruction cache with burst line fill.
// Define ICACHE_CACHEOP_EN to add the icop/icopreq/icopva cache-op port.
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        phi1,
  input  logic        phi2,
  input  logic [63:0] pc,
  input  logic [31:0] itlbpa,
`ifdef ICACHE_CACHEOP_EN
  input  logic [2:0]  icop,
  input  logic        icopreq,
  input  logic [63:0] icopva,
`endif
  input  logic        icfill,
  output logic [31:0] icinstr,
  output logic [20:0] ictag,
  output logic        icbusy,
  output logic        icerror,
  output logic [31:0] memaddr,
  output logic        memreq,
  input  logic        memack,
  input  logic [31:0] memrdata,
  input  logic        memvalid,
  input  logic        memerr,
  output logic [2:0]  fsm_state
);
  // Bus handshake: memreq is held with a stable memaddr until memack; after
  // that every cycle with memvalid=1 delivers the next ascending word, and
  // memerr (which outranks memvalid) aborts the burst.
  logic [2:0]         state;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [WORD_W-1:0]  word_cnt;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [LINES-1:0]   valid;
  logic               start_fill;
  logic [INDEX_W-1:0] start_index;
  logic               ram_we;
  logic [INDEX_W-1:0] pc_index;
  logic               unused_bits;

  assign pc_index    = line_index(pc);
  assign fsm_state   = state;
  assign memreq      = (state == ST_REQ);
  assign icerror     = (state == ST_ERR);
  assign ram_we      = (state == ST_BURST) && memvalid && !memerr;

`ifdef ICACHE_CACHEOP_EN
  logic               op_inv;
  logic [INDEX_W-1:0] op_index;
  logic               unused_op_bits;

  assign op_index       = line_index(icopva);
  assign unused_op_bits = ^{icopva[63:14], icopva[4:0]};
  assign icbusy = (state == ST_REQ) || (state == ST_BURST) || (state == ST_DONE)
                  || ((state == ST_IDLE) && icopreq);

  always_comb begin
    start_fill  = 1'b0;
    start_index = pc_index;
    op_inv      = 1'b0;
    if (state == ST_IDLE) begin
      if (icopreq) begin
        case (icop)
          OP_INDEX_INV: op_inv = 1'b1;
          OP_HIT_INV:   op_inv = valid[op_index] && (tag_mem[op_index] == itlbpa[31:12]);
          OP_FILL: begin
            start_fill  = 1'b1;
            start_index = op_index;
          end
          default: ;
        endcase
      end else if (icfill) begin
        start_fill = 1'b1;
      end
    end
  end
`else
  assign icbusy = (state == ST_REQ) || (state == ST_BURST) || (state == ST_DONE);

  always_comb begin
    start_fill  = 1'b0;
    start_index = pc_index;
    if ((state == ST_IDLE) && icfill) start_fill = 1'b1;
  end
`endif

  assign unused_bits = ^{phi1, pc[63:14], pc[1:0], itlbpa[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fill_index <= '0;
      fill_tag   <= '0;
      word_cnt   <= '0;
      memaddr    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_fill) begin
          state      <= ST_REQ;
          fill_index <= start_index;
          fill_tag   <= itlbpa[31:12];
          memaddr    <= {itlbpa[31:5], 5'b0};
          word_cnt   <= '0;
        end
        ST_REQ: begin
          if (memerr)      state <= ST_ERR;
          else if (memack) state <= ST_BURST;
        end
        ST_BURST: begin
          if (memerr) state <= ST_ERR;
          else if (memvalid) begin
            word_cnt <= word_cnt + 3'd1;
            if (word_cnt == 3'd7) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR: begin
          word_cnt <= '0;
          if (phi2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The line is invalid from fill start until DONE, so lookups never see a
  // partly written line as valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (start_fill) valid[start_index] <= 1'b0;
`ifdef ICACHE_CACHEOP_EN
      if (op_inv) valid[op_index] <= 1'b0;
`endif
      if (state == ST_DONE) valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_DONE) tag_mem[fill_index] <= fill_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ictag <= '0;
    else       ictag <= {valid[pc_index], tag_mem[pc_index]};
  end

  icache_ram u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (ram_we),
    .waddr ({fill_index, word_cnt}),
    .wdata (memrdata),
    .raddr (pc[13:2]),
    .rdata (icinstr)
  );
endmodule
